// File: rtl/segment_scan_driver.sv
// segment_scan_driver: 8-entry operand buffer scanned onto a 7-segment decoder.
// A prescaler paces the digit index. A host write port updates entries at any
// time. All outputs are registered and show the entry for the index that the
// next edge selects.
module segment_scan_driver #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_en,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       a1,
    output logic       a0,
    output logic       b1,
    output logic       b0,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       frame_start
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       mem_q [8];
    logic [3:0]       mem_d [8];
    logic [3:0]       opnd_q, opnd_d;
    logic             frame_q, frame_d;
    logic             tick;

    // Next-state logic: prescaler, index, buffer write, and operand select with
    // write-through so that a write to the selected slot shows up after one cycle.
    always_comb begin
        tick    = scan_en && (presc_q == PRESC_LAST);
        presc_d = presc_q;
        if (scan_en) begin
            presc_d = tick ? '0 : presc_q + CNT_W'(1);
        end
        idx_d = tick ? idx_q + 3'd1 : idx_q;
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
        opnd_d  = (wr_en && (wr_addr == idx_d)) ? wr_data : mem_q[idx_d];
        frame_d = tick && (idx_q == 3'd7);
    end

    // State and output registers; async reset clears everything including the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            opnd_q  <= '0;
            frame_q <= 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            opnd_q  <= opnd_d;
            frame_q <= frame_d;
            for (int unsigned i = 0; i < 8; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // The registered index doubles as the digit select.
    assign {x, y, z}          = idx_q;
    assign {a1, a0, b1, b0}   = opnd_q;
    assign frame_start        = frame_q;

endmodule
